// File: rtl/aud_i2s_tx.sv
// Stereo DAC serializer: one-frame holding buffer feeding an MSB-first shifter
// aligned to codec-mastered BCLK/DACLRCK, with I2S or left-justified framing.
module aud_i2s_tx #(
   parameter int DATA_W = 16,
   parameter int MODE   = 0,
   parameter int STEREO = 1
) (
   input  logic              i_bclk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_daclrck,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_left,
   input  logic [DATA_W-1:0] i_right,
   output logic              o_ready,
   output logic              o_aud_dacdat,
   output logic              o_underrun,
   output logic [7:0]        o_underrun_cnt,
   output logic              o_busy
);
   localparam int               CNT_W   = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SYNC  = 2'd1;
   localparam logic [1:0] ST_LEFT  = 2'd2;
   localparam logic [1:0] ST_RIGHT = 2'd3;

   logic [1:0]        state_reg, state_next;
   logic              lrck_q;
   logic              buf_full_reg;
   logic [DATA_W-1:0] buf_left_reg, buf_right_reg;
   logic [DATA_W-1:0] shift_reg, right_hold_reg;
   logic [CNT_W-1:0]  cnt_reg;

   logic              frame_start, right_start, xfer;
   logic              frame_load, chan_start, active_next;
   logic [DATA_W-1:0] chan_data, right_in;

   assign frame_start = lrck_q & ~i_daclrck;
   assign right_start = ~lrck_q & i_daclrck;
   assign o_ready     = ~buf_full_reg & i_en;
   assign xfer        = i_valid & o_ready;
   assign right_in    = (STEREO != 0) ? i_right : i_left;
   assign o_busy      = (state_reg == ST_LEFT) || (state_reg == ST_RIGHT);
   assign active_next = (state_next == ST_LEFT) || (state_next == ST_RIGHT);

   always_comb begin
      state_next = state_reg;
      frame_load = 1'b0;
      chan_start = 1'b0;
      chan_data  = right_hold_reg;
      case (state_reg)
         ST_IDLE:  if (i_en) state_next = ST_SYNC;
         ST_SYNC:  if (frame_start) begin
                      state_next = ST_LEFT;
                      frame_load = 1'b1;
                   end
         ST_LEFT:  if (right_start) begin
                      state_next = ST_RIGHT;
                      chan_start = 1'b1;
                   end
         ST_RIGHT: if (frame_start) begin
                      if (i_en) begin
                         state_next = ST_LEFT;
                         frame_load = 1'b1;
                      end else begin
                         state_next = ST_IDLE;
                      end
                   end
         default:  state_next = ST_IDLE;
      endcase
      // An empty buffer at frame start plays silence on both channels
      if (frame_load) begin
         chan_start = 1'b1;
         chan_data  = buf_full_reg ? buf_left_reg : '0;
      end
   end

   always_ff @(negedge i_bclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg      <= ST_IDLE;
         lrck_q         <= 1'b0;
         buf_full_reg   <= 1'b0;
         buf_left_reg   <= '0;
         buf_right_reg  <= '0;
         shift_reg      <= '0;
         right_hold_reg <= '0;
         cnt_reg        <= '0;
         o_aud_dacdat   <= 1'b0;
         o_underrun     <= 1'b0;
         o_underrun_cnt <= 8'd0;
      end else begin
         lrck_q     <= i_daclrck;
         state_reg  <= state_next;
         o_underrun <= frame_load & ~buf_full_reg;

         if (frame_load & ~buf_full_reg & (o_underrun_cnt != 8'hFF))
            o_underrun_cnt <= o_underrun_cnt + 8'd1;

         if (frame_load)
            right_hold_reg <= buf_full_reg ? buf_right_reg : '0;

         // A transfer can only happen with the buffer empty, so it never races the load
         if (xfer) begin
            buf_left_reg  <= i_left;
            buf_right_reg <= right_in;
            buf_full_reg  <= 1'b1;
         end else if ((state_reg == ST_IDLE) || (frame_load & buf_full_reg)) begin
            buf_full_reg <= 1'b0;
         end

         if (chan_start) begin
            if (MODE == 1) begin
               o_aud_dacdat <= chan_data[DATA_W-1];
               shift_reg    <= chan_data << 1;
               cnt_reg      <= CNT_W'(1);
            end else begin
               o_aud_dacdat <= 1'b0;
               shift_reg    <= chan_data;
               cnt_reg      <= '0;
            end
         end else if (active_next && (cnt_reg != CNT_MAX)) begin
            o_aud_dacdat <= shift_reg[DATA_W-1];
            shift_reg    <= shift_reg << 1;
            cnt_reg      <= cnt_reg + CNT_W'(1);
         end else begin
            o_aud_dacdat <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_aud_i2s_tx.sv
// Bench for aud_i2s_tx: three configurations driven from a shared BCLK/LRCK,
// checked against a frame-level model of buffer, framing and bit placement.
module tb_aud_i2s_tx;
   logic             bclk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic             lrck = 1'b1;
   logic [2:0]       vld = '0;
   logic [2:0][31:0] in_l = '0;
   logic [2:0][31:0] in_r = '0;
   logic [2:0]       rdy, dat, und, bsy;
   logic [2:0][7:0]  ucnt;

   int wv[3]  = '{16, 24, 16};
   int mdv[3] = '{0, 1, 1};
   int stv[3] = '{1, 1, 0};

   int checks = 0;
   int errors = 0;

   int          sel = 0;
   bit          hold = 0;
   bit          pend = 0;
   logic [31:0] pend_l = '0, pend_r = '0;

   // behavioural model state
   int          m_phase, m_j, m_ucnt;
   logic        m_prev;
   bit          m_full;
   logic [31:0] m_l, m_r, m_cur_l, m_cur_r, m_data;

   logic dat_q[$], und_q[$], rdy_q[$], edat_q[$], eund_q[$], erdy_q[$];
   int   f_idx[$];
   logic [31:0] sent_l[$], sent_r[$];

   always #5 bclk = ~bclk;

   aud_i2s_tx #(.DATA_W(16), .MODE(0), .STEREO(1)) u_a (
      .i_bclk(bclk), .i_rst_n(rst_n), .i_en(en), .i_daclrck(lrck), .i_valid(vld[0]),
      .i_left(in_l[0][15:0]), .i_right(in_r[0][15:0]), .o_ready(rdy[0]),
      .o_aud_dacdat(dat[0]), .o_underrun(und[0]), .o_underrun_cnt(ucnt[0]), .o_busy(bsy[0]));
   aud_i2s_tx #(.DATA_W(24), .MODE(1), .STEREO(1)) u_b (
      .i_bclk(bclk), .i_rst_n(rst_n), .i_en(en), .i_daclrck(lrck), .i_valid(vld[1]),
      .i_left(in_l[1][23:0]), .i_right(in_r[1][23:0]), .o_ready(rdy[1]),
      .o_aud_dacdat(dat[1]), .o_underrun(und[1]), .o_underrun_cnt(ucnt[1]), .o_busy(bsy[1]));
   aud_i2s_tx #(.DATA_W(16), .MODE(1), .STEREO(0)) u_c (
      .i_bclk(bclk), .i_rst_n(rst_n), .i_en(en), .i_daclrck(lrck), .i_valid(vld[2]),
      .i_left(in_l[2][15:0]), .i_right(in_r[2][15:0]), .o_ready(rdy[2]),
      .o_aud_dacdat(dat[2]), .o_underrun(und[2]), .o_underrun_cnt(ucnt[2]), .o_busy(bsy[2]));

   function automatic logic [31:0] msk();
      return (wv[sel] == 32) ? 32'hFFFF_FFFF : ((32'd1 << wv[sel]) - 32'd1);
   endfunction

   // Bit expected j cycles after a detected LRCK edge
   function automatic logic exp_bit(input logic [31:0] s, input int w, input int md, input int j);
      int k;
      k = (md == 1) ? j : j - 1;
      if (k < 0 || k >= w) return 1'b0;
      return s[w-1-k];
   endfunction

   function automatic logic [31:0] get_word(input int base, input int n);
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < n; i++) w = {w[30:0], dat_q[base+i]};
      return w;
   endfunction

   task automatic m_load(output logic u);
      if (m_full) begin
         m_cur_l = m_l; m_cur_r = m_r; m_full = 0; u = 1'b0;
      end else begin
         m_cur_l = '0; m_cur_r = '0; u = 1'b1;
         if (m_ucnt < 255) m_ucnt++;
      end
      m_data = m_cur_l;
   endtask

   task automatic cycle(input logic lr);
      logic acc, f_ev, r_ev, eu;
      @(posedge bclk);
      lrck = lr;
      vld[sel] = pend;
      in_l[sel] = pend_l;
      in_r[sel] = pend_r;
      #1;
      acc = pend && rdy[sel];
      rdy_q.push_back(rdy[sel]);
      erdy_q.push_back(!m_full && en);
      @(negedge bclk);
      f_ev = m_prev && !lr;
      r_ev = !m_prev && lr;
      m_prev = lr;
      eu = 1'b0;
      case (m_phase)
         0: if (en && f_ev) begin m_load(eu); m_phase = 1; m_j = 0; end
            else if (!en) m_full = 0;
         1: if (r_ev) begin m_phase = 2; m_j = 0; m_data = m_cur_r; end
            else m_j++;
         default: if (f_ev) begin
                     if (en) begin m_load(eu); m_phase = 1; m_j = 0; end
                     else m_phase = 0;
                  end else m_j++;
      endcase
      if (acc) begin
         m_full = 1;
         m_l = pend_l & msk();
         m_r = (stv[sel] != 0) ? (pend_r & msk()) : (pend_l & msk());
         if (!hold) pend = 0;
      end
      #1;
      dat_q.push_back(dat[sel]);
      und_q.push_back(und[sel]);
      edat_q.push_back((m_phase == 0) ? 1'b0 : exp_bit(m_data, wv[sel], mdv[sel], m_j));
      eund_q.push_back(eu);
   endtask

   task automatic offer();
      pend = 1;
      pend_l = $urandom & msk();
      pend_r = $urandom & msk();
      sent_l.push_back(pend_l);
      sent_r.push_back((stv[sel] != 0) ? pend_r : pend_l);
   endtask

   task automatic run_frame(input int hl, input int hr, input bit do_offer, input int en_off);
      f_idx.push_back(dat_q.size());
      for (int i = 0; i < hl; i++) begin
         if (do_offer && i == 1) offer();
         if (i == en_off) en = 0;
         cycle(1'b0);
      end
      for (int i = 0; i < hr; i++) cycle(1'b1);
   endtask

   task automatic start(input int s, input bit h);
      sel = s; hold = h; pend = 0; en = 0; lrck = 1'b1; vld = '0;
      rst_n = 0;
      repeat (2) @(posedge bclk);
      rst_n = 1;
      m_phase = 0; m_j = 0; m_ucnt = 0; m_prev = 1'b0; m_full = 0;
      m_l = '0; m_r = '0; m_cur_l = '0; m_cur_r = '0; m_data = '0;
      dat_q.delete(); und_q.delete(); rdy_q.delete();
      edat_q.delete(); eund_q.delete(); erdy_q.delete();
      f_idx.delete(); sent_l.delete(); sent_r.delete();
      en = 1;
      repeat (3) cycle(1'b1);
   endtask

   task automatic test_reset();
      rst_n = 0; en = 0; vld = '0;
      repeat (3) @(posedge bclk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (dat[i] !== 1'b0 || und[i] !== 1'b0 || ucnt[i] !== 8'd0 || bsy[i] !== 1'b0 || rdy[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state inst %0d: dat=%b und=%b cnt=%0d busy=%b rdy=%b, required all 0",
                     i, dat[i], und[i], ucnt[i], bsy[i], rdy[i]);
         end
      end
      rst_n = 1; en = 1;
      #1;
      checks++;
      if (rdy !== 3'b111) begin
         errors++;
         $display("FAIL reset_ready: got %b required 111", rdy);
      end
      $display("test_reset done");
   endtask

   task automatic test_i2s_basic();
      int fi, und_sum;
      logic zor;
      start(0, 0);
      pend = 1; pend_l = 32'hA5C3; pend_r = 32'h0F01;
      repeat (2) cycle(1'b1);
      repeat (5) run_frame(32, 32, 1, -1);
      fi = f_idx[0];
      checks++;
      if (get_word(fi + 1, 16) !== 32'hA5C3) begin
         errors++;
         $display("FAIL i2s_left_word: got %h required a5c3", get_word(fi + 1, 16));
      end
      checks++;
      if (get_word(fi + 33, 16) !== 32'h0F01) begin
         errors++;
         $display("FAIL i2s_right_word: got %h required 0f01", get_word(fi + 33, 16));
      end
      zor = dat_q[fi] | dat_q[fi + 32];
      for (int i = 17; i < 32; i++) zor = zor | dat_q[fi + i] | dat_q[fi + 32 + i];
      checks++;
      if (zor !== 1'b0) begin
         errors++;
         $display("FAIL i2s_zero_slots: got %b required 0", zor);
      end
      und_sum = 0;
      foreach (und_q[i]) und_sum += int'(und_q[i]);
      checks++;
      if (und_sum != 0) begin
         errors++;
         $display("FAIL i2s_no_underrun: got %0d pulses required 0", und_sum);
      end
      for (int i = 0; i < dat_q.size(); i++) begin
         checks++;
         if (dat_q[i] !== edat_q[i] || und_q[i] !== eund_q[i] || rdy_q[i] !== erdy_q[i]) begin
            errors++;
            $display("FAIL i2s_stream cyc %0d: dat/und/rdy=%b%b%b required %b%b%b",
                     i, dat_q[i], und_q[i], rdy_q[i], edat_q[i], eund_q[i], erdy_q[i]);
         end
      end
      $display("test_i2s_basic done: %0d frames", f_idx.size());
   endtask

   task automatic test_lj24();
      int fi;
      start(1, 0);
      pend = 1; pend_l = 32'h800001; pend_r = $urandom & 32'hFF_FFFF;
      repeat (2) cycle(1'b1);
      repeat (3) run_frame(32, 32, 1, -1);
      fi = f_idx[0];
      checks++;
      if (get_word(fi, 24) !== 32'h800001) begin
         errors++;
         $display("FAIL lj24_left_word: got %h required 800001", get_word(fi, 24));
      end
      checks++;
      if (get_word(fi + 24, 8) !== 32'h0) begin
         errors++;
         $display("FAIL lj24_tail_zero: got %h required 0", get_word(fi + 24, 8));
      end
      for (int i = 0; i < dat_q.size(); i++) begin
         checks++;
         if (dat_q[i] !== edat_q[i] || und_q[i] !== eund_q[i] || rdy_q[i] !== erdy_q[i]) begin
            errors++;
            $display("FAIL lj24_stream cyc %0d: dat/und/rdy=%b%b%b required %b%b%b",
                     i, dat_q[i], und_q[i], rdy_q[i], edat_q[i], eund_q[i], erdy_q[i]);
         end
      end
      $display("test_lj24 done: %0d frames", f_idx.size());
   endtask

   task automatic test_underrun();
      int und_sum, ones;
      start(0, 0);
      repeat (300) run_frame(8, 8, 0, -1);
      und_sum = 0; ones = 0;
      foreach (und_q[i]) und_sum += int'(und_q[i]);
      foreach (dat_q[i]) ones += int'(dat_q[i]);
      checks++;
      if (und_sum != 300) begin
         errors++;
         $display("FAIL underrun_pulses: got %0d required 300", und_sum);
      end
      checks++;
      if (ones != 0) begin
         errors++;
         $display("FAIL underrun_silence: got %0d one bits required 0", ones);
      end
      checks++;
      if (ucnt[0] !== 8'd255) begin
         errors++;
         $display("FAIL underrun_sat: got %0d required 255", ucnt[0]);
      end
      for (int i = 0; i < dat_q.size(); i++) begin
         checks++;
         if (dat_q[i] !== edat_q[i] || und_q[i] !== eund_q[i] || rdy_q[i] !== erdy_q[i]) begin
            errors++;
            $display("FAIL underrun_stream cyc %0d: dat/und/rdy=%b%b%b required %b%b%b",
                     i, dat_q[i], und_q[i], rdy_q[i], edat_q[i], eund_q[i], erdy_q[i]);
         end
      end
      $display("test_underrun done: %0d frames", f_idx.size());
   endtask

   task automatic test_mono_backpressure();
      int fi, rsum;
      start(2, 1);
      pend = 1; pend_l = 32'h1234; pend_r = $urandom & 32'hFFFF;
      repeat (2) cycle(1'b1);
      repeat (4) run_frame(20, 20, 0, -1);
      for (int k = 0; k < 4; k++) begin
         fi = f_idx[k];
         checks++;
         if (get_word(fi, 16) !== 32'h1234 || get_word(fi + 20, 16) !== 32'h1234) begin
            errors++;
            $display("FAIL mono_words frame %0d: L=%h R=%h required 1234 both",
                     k, get_word(fi, 16), get_word(fi + 20, 16));
         end
         rsum = 0;
         for (int i = 0; i < 40; i++) rsum += int'(rdy_q[fi + i]);
         checks++;
         if (rdy_q[fi + 1] !== 1'b1 || rsum != 1) begin
            errors++;
            $display("FAIL mono_ready frame %0d: rdy@F+1=%b pulses=%0d required 1 and 1",
                     k, rdy_q[fi + 1], rsum);
         end
      end
      for (int i = 0; i < dat_q.size(); i++) begin
         checks++;
         if (dat_q[i] !== edat_q[i] || und_q[i] !== eund_q[i] || rdy_q[i] !== erdy_q[i]) begin
            errors++;
            $display("FAIL mono_stream cyc %0d: dat/und/rdy=%b%b%b required %b%b%b",
                     i, dat_q[i], und_q[i], rdy_q[i], edat_q[i], eund_q[i], erdy_q[i]);
         end
      end
      $display("test_mono_backpressure done: %0d frames", f_idx.size());
   endtask

   task automatic test_short_halfframe();
      int und_sum;
      start(2, 0);
      offer();
      repeat (2) cycle(1'b1);
      repeat (6) run_frame(12, 12, 1, -1);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (get_word(f_idx[k], 12) !== (sent_l[k] >> 4) || get_word(f_idx[k] + 12, 12) !== (sent_r[k] >> 4)) begin
            errors++;
            $display("FAIL short_trunc frame %0d: L=%h R=%h required %h %h", k,
                     get_word(f_idx[k], 12), get_word(f_idx[k] + 12, 12), sent_l[k] >> 4, sent_r[k] >> 4);
         end
      end
      und_sum = 0;
      foreach (und_q[i]) und_sum += int'(und_q[i]);
      checks++;
      if (und_sum != 0) begin
         errors++;
         $display("FAIL short_no_underrun: got %0d required 0", und_sum);
      end
      for (int i = 0; i < dat_q.size(); i++) begin
         checks++;
         if (dat_q[i] !== edat_q[i] || und_q[i] !== eund_q[i] || rdy_q[i] !== erdy_q[i]) begin
            errors++;
            $display("FAIL short_stream cyc %0d: dat/und/rdy=%b%b%b required %b%b%b",
                     i, dat_q[i], und_q[i], rdy_q[i], edat_q[i], eund_q[i], erdy_q[i]);
         end
      end
      $display("test_short_halfframe done: %0d frames", f_idx.size());
   endtask

   task automatic test_disable_midframe();
      int base, ones;
      start(0, 0);
      offer();
      repeat (2) cycle(1'b1);
      run_frame(32, 32, 0, 5);
      checks++;
      if (bsy[0] !== 1'b1) begin
         errors++;
         $display("FAIL disable_busy_right: got %b required 1", bsy[0]);
      end
      checks++;
      if (get_word(f_idx[0] + 33, 16) !== sent_r[0]) begin
         errors++;
         $display("FAIL disable_right_done: got %h required %h", get_word(f_idx[0] + 33, 16), sent_r[0]);
      end
      base = dat_q.size();
      repeat (6) cycle(1'b0);
      ones = 0;
      for (int i = base; i < dat_q.size(); i++) ones += int'(dat_q[i]);
      checks++;
      if (ones != 0 || bsy[0] !== 1'b0) begin
         errors++;
         $display("FAIL disable_idle: ones=%0d busy=%b required 0 and 0", ones, bsy[0]);
      end
      for (int i = 0; i < dat_q.size(); i++) begin
         checks++;
         if (dat_q[i] !== edat_q[i] || und_q[i] !== eund_q[i] || rdy_q[i] !== erdy_q[i]) begin
            errors++;
            $display("FAIL disable_stream cyc %0d: dat/und/rdy=%b%b%b required %b%b%b",
                     i, dat_q[i], und_q[i], rdy_q[i], edat_q[i], eund_q[i], erdy_q[i]);
         end
      end
      $display("test_disable_midframe done");
   endtask

   task automatic test_reset_midframe();
      int fi;
      start(0, 0);
      run_frame(32, 32, 0, -1);
      pend = 1; pend_l = 32'hFFFF; pend_r = 32'hFFFF;
      run_frame(32, 32, 0, -1);
      fi = dat_q.size();
      repeat (5) cycle(1'b0);
      for (int i = 0; i < dat_q.size(); i++) begin
         checks++;
         if (dat_q[i] !== edat_q[i] || und_q[i] !== eund_q[i] || rdy_q[i] !== erdy_q[i]) begin
            errors++;
            $display("FAIL rstmid_stream cyc %0d: dat/und/rdy=%b%b%b required %b%b%b",
                     i, dat_q[i], und_q[i], rdy_q[i], edat_q[i], eund_q[i], erdy_q[i]);
         end
      end
      @(posedge bclk);
      #2;
      checks++;
      if (dat[0] !== 1'b1 || ucnt[0] !== 8'd2 || bsy[0] !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_before: dat=%b cnt=%0d busy=%b required 1 2 1", dat[0], ucnt[0], bsy[0]);
      end
      rst_n = 0;
      #1;
      checks++;
      if (dat[0] !== 1'b0 || ucnt[0] !== 8'd0 || bsy[0] !== 1'b0 || und[0] !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_async: dat=%b cnt=%0d busy=%b und=%b required all 0",
                  dat[0], ucnt[0], bsy[0], und[0]);
      end
      $display("test_reset_midframe done: frame start at cycle %0d", fi);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_i2s_basic();
      test_lj24();
      test_underrun();
      test_mono_backpressure();
      test_short_halfframe();
      test_disable_midframe();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
